pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register and next generation of the fixed IF/ID latch. Carries a PC+4 word and an instruction word between two pipeline stages. Replaces the single load-enable with a valid/ready handshake, backed by a 2-entry skid buffer so that ready never combinationally depends on the downstream stage. Adds synchronous flush and bubble (NOP) presentation; instantiated between IF/ID and any later stage pair.

---
 rtl/pipe_skid_reg.sv | 123 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register carrying PC+4 and instruction over a valid/ready handshake, with a 2-entry skid buffer, flush and bubble output.
// Defining PIPE_SKID_PERF_EN adds saturating stall_cnt / flush_cnt counters and their ports.
module pipe_skid_reg #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0
`ifdef PIPE_SKID_PERF_EN
  ,
  parameter int                CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc4,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc4,
  output logic [INST_W-1:0] out_inst,
`ifdef PIPE_SKID_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: a word moves on a side only in a cycle where that side's valid and ready are both 1;
  // in_ready and out_valid decode from r_state alone, so neither depends on in_valid or out_ready.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_main_pc4;
  logic [INST_W-1:0] r_main_inst;
  logic [PC_W-1:0]   r_skid_pc4;
  logic [INST_W-1:0] r_skid_inst;
  logic              w_in_fire;
  logic              w_out_fire;

  assign in_ready   = (r_state != S_FULL);
  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign dbg_state  = r_state;

  // Main data can be stale after a drain to EMPTY, so the bubble value is forced here.
  assign out_pc4  = out_valid ? r_main_pc4  : '0;
  assign out_inst = out_valid ? r_main_inst : NOP_INST;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_EMPTY;
      r_main_pc4  <= '0;
      r_main_inst <= NOP_INST;
      r_skid_pc4  <= '0;
      r_skid_inst <= NOP_INST;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_main_pc4  <= '0;
      r_main_inst <= NOP_INST;
      r_skid_pc4  <= '0;
      r_skid_inst <= NOP_INST;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= S_ONE;
            r_main_pc4  <= in_pc4;
            r_main_inst <= in_inst;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_pc4  <= in_pc4;
            r_main_inst <= in_inst;
          end else if (w_in_fire) begin
            r_state     <= S_FULL;
            r_skid_pc4  <= in_pc4;
            r_skid_inst <= in_inst;
          end else if (w_out_fire) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            r_state     <= S_ONE;
            r_main_pc4  <= r_skid_pc4;
            r_main_inst <= r_skid_inst;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters survive flush; only clr clears them.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush && (r_state != S_EMPTY) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a default instance and a PC_W=16/INST_W=64/NOP=0x13 instance share stimulus and a queue model.
module tb_pipe_skid_reg;
  localparam int CNT_W_TB = 3;
  localparam int CNT_MAX  = (1 << CNT_W_TB) - 1;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_pc4 = '0;
  logic [31:0] in_inst = '0;

  logic        in_ready0, out_valid0;
  logic [31:0] out_pc4_0, out_inst0;
  logic [1:0]  dbg0;
  logic        in_ready1, out_valid1;
  logic [15:0] out_pc4_1;
  logic [63:0] out_inst1;
  logic [1:0]  dbg1;
  logic [15:0] in_pc4_1;
  logic [63:0] in_inst1;
`ifdef PIPE_SKID_PERF_EN
  logic [CNT_W_TB-1:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
`endif

  assign in_pc4_1 = in_pc4[15:0];
  assign in_inst1 = {in_inst, ~in_inst};

  pipe_skid_reg #(
    .PC_W(32), .INST_W(32), .NOP_INST(32'h0)
`ifdef PIPE_SKID_PERF_EN
    , .CNT_W(CNT_W_TB)
`endif
  ) dut0 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .in_pc4(in_pc4), .in_inst(in_inst), .flush(flush), .out_valid(out_valid0),
    .out_ready(out_ready), .out_pc4(out_pc4_0), .out_inst(out_inst0),
`ifdef PIPE_SKID_PERF_EN
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0),
`endif
    .dbg_state(dbg0)
  );

  pipe_skid_reg #(
    .PC_W(16), .INST_W(64), .NOP_INST(64'h13)
`ifdef PIPE_SKID_PERF_EN
    , .CNT_W(CNT_W_TB)
`endif
  ) dut1 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .in_pc4(in_pc4_1), .in_inst(in_inst1), .flush(flush), .out_valid(out_valid1),
    .out_ready(out_ready), .out_pc4(out_pc4_1), .out_inst(out_inst1),
`ifdef PIPE_SKID_PERF_EN
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1),
`endif
    .dbg_state(dbg1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two {pc4,inst} words.
  logic [63:0] exp_q[$];
  int m_stall = 0;
  int m_flush = 0;

  always @(posedge clk or posedge clr) begin : model
    bit m_in_fire, m_out_fire;
    if (clr) begin
      exp_q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_in_fire  = in_valid && (exp_q.size() < 2);
      m_out_fire = (exp_q.size() > 0) && out_ready;
      if ((exp_q.size() > 0) && !out_ready && (m_stall < CNT_MAX)) m_stall++;
      if (flush && (exp_q.size() > 0) && (m_flush < CNT_MAX)) m_flush++;
      if (flush) exp_q.delete();
      else begin
        if (m_out_fire) void'(exp_q.pop_front());
        if (m_in_fire) exp_q.push_back({in_pc4, in_inst});
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin : cmp
    bit          v;
    logic [63:0] h;
    if (cmp_en) begin
      v = (exp_q.size() > 0);
      h = v ? exp_q[0] : 64'd0;
      check("m0_out_valid", out_valid0, v);
      check("m0_in_ready", in_ready0, exp_q.size() < 2);
      check("m0_state", dbg0, exp_q.size());
      check("m0_out_pc4", out_pc4_0, v ? h[63:32] : 32'd0);
      check("m0_out_inst", out_inst0, v ? h[31:0] : 32'd0);
      check("m1_out_valid", out_valid1, v);
      check("m1_in_ready", in_ready1, exp_q.size() < 2);
      check("m1_out_pc4", out_pc4_1, v ? h[47:32] : 16'd0);
      check("m1_out_inst", out_inst1, v ? {h[31:0], ~h[31:0]} : 64'h13);
`ifdef PIPE_SKID_PERF_EN
      check("m0_stall_cnt", stall_cnt0, m_stall);
      check("m0_flush_cnt", flush_cnt0, m_flush);
      check("m1_stall_cnt", stall_cnt1, m_stall);
      check("m1_flush_cnt", flush_cnt1, m_flush);
`endif
    end
  end

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input bit rdy, input bit fl);
    in_valid = v; in_pc4 = pc; in_inst = inst; out_ready = rdy; flush = fl;
  endtask

  logic [31:0] s_pc[3];
  logic [31:0] s_inst[3];

  initial begin
    s_pc[0] = 32'h4; s_pc[1] = 32'h8; s_pc[2] = 32'hC;
    s_inst[0] = 32'h8C010000; s_inst[1] = 32'h8C020000; s_inst[2] = 32'h8C030000;

    #1 clr = 1'b1;
    #2;
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_in_ready", in_ready0, 1'b1);
    check("rst_out_inst", out_inst0, 32'h0);
    check("rst_out_pc4", out_pc4_0, 32'h0);
    check("rst_m1_out_inst", out_inst1, 64'h13);
    @(negedge clk);
    clr = 1'b0;
    cmp_en = 1'b1;

    // Streaming
    drive(1, s_pc[0], s_inst[0], 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stream_valid", out_valid0, 1'b1);
      check("stream_ready", in_ready0, 1'b1);
      check("stream_pc4", out_pc4_0, s_pc[i]);
      check("stream_inst", out_inst0, s_inst[i]);
      if (i < 2) drive(1, s_pc[i+1], s_inst[i+1], 1, 0);
      else drive(0, 32'h0, 32'h0, 1, 0);
    end
    @(negedge clk);
    check("stream_drained", out_valid0, 1'b0);

    // Backpressure into FULL, then drain in order
    drive(1, 32'h10, 32'hA, 0, 0);
    @(negedge clk);
    check("bp_a_pc4", out_pc4_0, 32'h10);
    check("bp_one_ready", in_ready0, 1'b1);
    drive(1, 32'h14, 32'hB, 0, 0);
    @(negedge clk);
    check("bp_full_ready", in_ready0, 1'b0);
    check("bp_full_state", dbg0, 2'd2);
    check("bp_hold_pc4", out_pc4_0, 32'h10);
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    check("bp_b_pc4", out_pc4_0, 32'h14);
    check("bp_b_valid", out_valid0, 1'b1);
    @(negedge clk);
    check("bp_empty_valid", out_valid0, 1'b0);
    check("bp_empty_state", dbg0, 2'd0);

    // Flush while FULL, then flush in ONE with a simultaneous acceptance
    drive(1, 32'h30, 32'hC0, 0, 0);
    @(negedge clk);
    drive(1, 32'h34, 32'hC1, 0, 0);
    @(negedge clk);
    drive(1, 32'h38, 32'hC2, 0, 1);
    @(negedge clk);
    check("fl_full_valid", out_valid0, 1'b0);
    check("fl_full_inst", out_inst0, 32'h0);
    check("fl_full_pc4", out_pc4_0, 32'h0);
    check("fl_full_ready", in_ready0, 1'b1);
    check("fl_full_m1_inst", out_inst1, 64'h13);
    drive(1, 32'h40, 32'hC3, 0, 0);
    @(negedge clk);
    drive(1, 32'h44, 32'hC4, 0, 1);
    @(negedge clk);
    check("fl_one_valid", out_valid0, 1'b0);
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    check("fl_dropped", out_valid0, 1'b0);

    // Asynchronous reset while FULL
    drive(1, 32'h50, 32'hD0, 0, 0);
    @(negedge clk);
    drive(1, 32'h54, 32'hD1, 0, 0);
    @(negedge clk);
    check("ar_full_state", dbg0, 2'd2);
    #2 clr = 1'b1;
    #1;
    check("ar_out_valid", out_valid0, 1'b0);
    check("ar_in_ready", in_ready0, 1'b1);
    check("ar_out_inst", out_inst0, 32'h0);
    check("ar_out_pc4", out_pc4_0, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    drive(1, 32'h20, 32'hE0, 1, 0);
    @(negedge clk);
    check("ar_first_valid", out_valid0, 1'b1);
    check("ar_first_pc4", out_pc4_0, 32'h20);
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);

`ifdef PIPE_SKID_PERF_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("perf_rst_stall", stall_cnt0, 3'd0);
    drive(1, 32'h60, 32'hF0, 0, 0);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 0, 0);
    repeat (5) @(negedge clk);
    check("perf_stall5", stall_cnt0, 3'd5);
    repeat (5) @(negedge clk);
    check("perf_stall_sat", stall_cnt0, 3'd7);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    drive(0, 32'h0, 32'h0, 1, 1);
    repeat (2) @(negedge clk);
    check("perf_flush_empty", flush_cnt0, 3'd0);
    drive(1, 32'h70, 32'hF1, 1, 0);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 0, 1);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 1, 0);
    check("perf_flush_one", flush_cnt0, 3'd1);
    @(negedge clk);
`endif

    // Randomized traffic with rare flushes and occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom(), $urandom(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 clr = 1'b1;
        #1 clr = 1'b0;
      end
      @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
